// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C configuration-table sequencer: op codes,
// table entry layout and FSM states.
package i2c_cfg_pkg;

    localparam logic [7:0] OP_WRITE = 8'h00;
    localparam logic [7:0] OP_DELAY = 8'h01;
    localparam logic [7:0] OP_END   = 8'hFF;

    localparam int OP_LSB  = 24;
    localparam int PTR_LSB = 8;
    localparam int DAT_LSB = 0;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_GO_HI, S_WAIT_START, S_WAIT_DONE,
        S_CHECK, S_NEXT, S_DELAY, S_DONE, S_ERROR
    } cfg_state_e;

    function automatic logic [7:0] ent_op(input logic [31:0] e);
        return e[OP_LSB +: 8];
    endfunction

    function automatic logic [15:0] ent_ptr(input logic [31:0] e);
        return e[PTR_LSB +: 16];
    endfunction

    function automatic logic [7:0] ent_dat(input logic [31:0] e);
        return e[DAT_LSB +: 8];
    endfunction

endpackage

// File: rtl/i2c_cfg_sync2.sv
// Two-flop synchroniser bringing an engine status bit into the CLK domain.
module i2c_cfg_sync2 (
    input  logic CLK,
    input  logic RESET_N,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) sync_q <= '0;
        else          sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks an external register-init table and drives one I2C write engine per
// entry, with NACK/timeout retries, inline delays and BUSY/DONE/ERR status.
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int         TABLE_AW   = 8,
    parameter logic [7:0] SLAVE_ADDR = 8'h6C,
    parameter int         GO_HOLD    = 8,
    parameter int         DELAY_TICK = 50000,
    parameter int         TIMEOUT    = 1000000,
    parameter int         MAX_RETRY  = 3
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                START,
    output logic [TABLE_AW-1:0] TBL_ADDR,
    input  logic [31:0]         TBL_DATA,
    output logic                WR_GO,
    output logic [15:0]         WR_POINTER,
    output logic [7:0]          WR_DATA,
    output logic [7:0]          WR_SLAVE_ADDRESS,
    input  logic                WR_END_OK,
    input  logic                WR_ACK_OK,
    output logic                CFG_BUSY,
    output logic                CFG_DONE,
    output logic                CFG_ERR,
    output logic [TABLE_AW-1:0] ERR_INDEX
);

    localparam int CNT_MAX = (TIMEOUT > GO_HOLD) ? TIMEOUT : GO_HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int DW      = 16 + $clog2(DELAY_TICK + 1);

    cfg_state_e          state_q;
    logic [TABLE_AW-1:0] idx_q, erri_q;
    logic [CW-1:0]       cnt_q;
    logic [RW-1:0]       retry_q;
    logic [DW-1:0]       dly_q;
    logic                tmo_q, start_q, go_q, busy_q, done_q, err_q;
    logic [15:0]         ptr_q;
    logic [7:0]          dat_q;
    logic                end_ok_s, ack_ok_s, start_edge;

    i2c_cfg_sync2 u_sync_end (.CLK(CLK), .RESET_N(RESET_N), .d_i(WR_END_OK), .q_o(end_ok_s));
    i2c_cfg_sync2 u_sync_ack (.CLK(CLK), .RESET_N(RESET_N), .d_i(WR_ACK_OK), .q_o(ack_ok_s));

    assign start_edge = START & ~start_q & ~busy_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            erri_q  <= '0;
            cnt_q   <= '0;
            retry_q <= '0;
            dly_q   <= '0;
            tmo_q   <= 1'b0;
            start_q <= 1'b0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
            dat_q   <= '0;
        end else begin
            start_q <= START;
            case (state_q)
                S_IDLE: if (start_edge) begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    idx_q   <= '0;
                    retry_q <= '0;
                    busy_q  <= 1'b1;
                    state_q <= S_FETCH;
                end
                // TBL_ADDR tracks idx_q, so the ROM has had the address since FETCH.
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: case (ent_op(TBL_DATA))
                    OP_WRITE: begin
                        ptr_q   <= ent_ptr(TBL_DATA);
                        dat_q   <= ent_dat(TBL_DATA);
                        go_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_GO_HI;
                    end
                    OP_DELAY: begin
                        dly_q   <= DW'(ent_ptr(TBL_DATA)) * DW'(DELAY_TICK);
                        state_q <= S_DELAY;
                    end
                    default: state_q <= S_DONE;
                endcase
                S_GO_HI: if (cnt_q == CW'(GO_HOLD - 1)) begin
                    go_q    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_WAIT_START;
                end else cnt_q <= cnt_q + 1'b1;
                S_WAIT_START: if (!end_ok_s) begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_q   <= '0;
                    tmo_q   <= 1'b1;
                    state_q <= S_CHECK;
                end else cnt_q <= cnt_q + 1'b1;
                S_WAIT_DONE: if (end_ok_s) begin
                    cnt_q   <= '0;
                    tmo_q   <= 1'b0;
                    state_q <= S_CHECK;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_q   <= '0;
                    tmo_q   <= 1'b1;
                    state_q <= S_CHECK;
                end else cnt_q <= cnt_q + 1'b1;
                // A timed-out attempt counts as a NACK regardless of ACK_OK.
                S_CHECK: if (ack_ok_s && !tmo_q) begin
                    retry_q <= '0;
                    state_q <= S_NEXT;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_q <= retry_q + 1'b1;
                    go_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_GO_HI;
                end else state_q <= S_ERROR;
                S_NEXT: if (idx_q == '1) state_q <= S_DONE;
                else begin
                    idx_q   <= idx_q + 1'b1;
                    state_q <= S_FETCH;
                end
                S_DELAY: if (dly_q == '0) state_q <= S_NEXT;
                else dly_q <= dly_q - 1'b1;
                S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_ERROR: begin
                    busy_q  <= 1'b0;
                    err_q   <= 1'b1;
                    erri_q  <= idx_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign TBL_ADDR         = idx_q;
    assign WR_GO            = go_q;
    assign WR_POINTER       = ptr_q;
    assign WR_DATA          = dat_q;
    assign WR_SLAVE_ADDRESS = SLAVE_ADDR;
    assign CFG_BUSY         = busy_q;
    assign CFG_DONE         = done_q;
    assign CFG_ERR          = err_q;
    assign ERR_INDEX        = erri_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Randomised and directed bench: a table-walk reference model predicts the
// write transactions and final status; an async engine model answers them.
`timescale 1ns/100ps
module tb_i2c_cfg_sequencer;

    localparam int AW   = 3;
    localparam int NENT = 1 << AW;
    localparam int MAXR = 3;

    typedef struct { logic [15:0] ptr; logic [7:0] dat; } xfer_t;

    logic          clk, pt_ck, rst_n, start;
    logic [AW-1:0] tbl_addr, err_index;
    logic [31:0]   tbl_data;
    logic          wr_go, end_ok, ack_ok, busy, done, err;
    logic [15:0]   wr_ptr;
    logic [7:0]    wr_dat, wr_sa;

    logic [31:0] rom [NENT];
    xfer_t       exp_q[$], got_q[$];
    int          got_w[$];
    bit          ack_plan[$];
    bit          eng_stuck;
    int          eng_extra, n_chk, n_err;

    i2c_cfg_sequencer #(
        .TABLE_AW(AW), .SLAVE_ADDR(8'h6C), .GO_HOLD(8),
        .DELAY_TICK(10), .TIMEOUT(100), .MAX_RETRY(MAXR)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .START(start),
        .TBL_ADDR(tbl_addr), .TBL_DATA(tbl_data),
        .WR_GO(wr_go), .WR_POINTER(wr_ptr), .WR_DATA(wr_dat),
        .WR_SLAVE_ADDRESS(wr_sa), .WR_END_OK(end_ok), .WR_ACK_OK(ack_ok),
        .CFG_BUSY(busy), .CFG_DONE(done), .CFG_ERR(err), .ERR_INDEX(err_index)
    );

    initial begin clk = 0; forever #5 clk = ~clk; end
    // Engine clock phase never coincides with a CLK edge.
    initial begin pt_ck = 0; #3.3; forever #13.5 pt_ck = ~pt_ck; end

    // Synchronous table ROM: data valid one CLK after address.
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // Engine model: drops END_OK on GO, answers from the ack plan.
    initial begin
        end_ok = 1'b1; ack_ok = 1'b0;
        forever begin
            @(posedge pt_ck);
            if (wr_go && !eng_stuck) begin
                end_ok = 1'b0; ack_ok = 1'b0;
                repeat (4 + $urandom_range(0, 3) + eng_extra) @(posedge pt_ck);
                ack_ok = (ack_plan.size() > 0) ? ack_plan.pop_front() : 1'b1;
                end_ok = 1'b1;
                while (wr_go) @(posedge pt_ck);
            end
        end
    end

    // GO pulse monitor.
    initial begin
        int w;
        w = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) w = 0;
            else if (wr_go) begin
                if (w == 0) got_q.push_back('{wr_ptr, wr_dat});
                w++;
            end else if (w != 0) begin
                got_w.push_back(w);
                w = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wr(input logic [15:0] p, input logic [7:0] d);
        return {8'h00, p, d};
    endfunction
    function automatic logic [31:0] dl(input logic [15:0] n);
        return {8'h01, n, 8'h00};
    endfunction
    localparam logic [31:0] ENDE = 32'hFF00_0000;

    // Reference: walk the table; nk[i] NACKs precede the ACK of write entry i.
    task automatic model(input int nk[NENT], output bit e_err, output int e_idx);
        exp_q.delete(); ack_plan.delete();
        e_err = 0; e_idx = 0;
        for (int i = 0; i < NENT; i++) begin
            logic [7:0] op;
            op = rom[i][31:24];
            if (op == 8'h00) begin
                int n;
                n = (nk[i] > MAXR) ? MAXR + 1 : nk[i] + 1;
                for (int a = 0; a < n; a++) begin
                    exp_q.push_back('{rom[i][23:8], rom[i][7:0]});
                    ack_plan.push_back(a >= nk[i]);
                end
                if (nk[i] > MAXR) begin e_err = 1; e_idx = i; return; end
            end else if (op != 8'h01) return;
        end
    endtask

    task automatic run(input int nk[NENT], input bit poke, output int cyc);
        bit e_err, seen;
        int e_idx;
        model(nk, e_err, e_idx);
        if (eng_stuck) ack_plan.delete();
        got_q.delete(); got_w.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0; seen = 0;
        while (cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (poke) start = (cyc == 30);
            if (busy) seen = 1;
            if (seen && !busy) break;
        end
        start = 1'b0;
        chk("finished", 32'(seen && !busy), 1);
        chk("done", 32'(done), 32'(!e_err));
        chk("err", 32'(err), 32'(e_err));
        if (e_err) chk("err_index", 32'(err_index), 32'(e_idx));
        chk("n_go", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk("ptr", 32'(got_q[i].ptr), 32'(exp_q[i].ptr));
            chk("dat", 32'(got_q[i].dat), 32'(exp_q[i].dat));
        end
        for (int i = 0; i < got_w.size(); i++) chk("go_width", 32'(got_w[i]), 8);
    endtask

    task automatic set_rom(input logic [31:0] t[NENT]);
        for (int i = 0; i < NENT; i++) rom[i] = t[i];
    endtask

    initial begin
        logic [31:0] t[NENT];
        int nk[NENT];
        int cyc, r;
        n_chk = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; eng_stuck = 0; eng_extra = 0;
        for (int i = 0; i < NENT; i++) rom[i] = ENDE;
        repeat (3) @(negedge clk);
        chk("rst_tbl_addr", 32'(tbl_addr), 0);
        chk("rst_go", 32'(wr_go), 0);
        chk("rst_ptr", 32'(wr_ptr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("slave_addr", 32'(wr_sa), 32'h6C);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Two writes, always ACK.
        set_rom('{wr(16'h0100, 8'h01), wr(16'h3030, 8'h55), ENDE, ENDE, ENDE, ENDE, ENDE, ENDE});
        run('{0, 0, 0, 0, 0, 0, 0, 0}, 0, cyc);

        // Entry 1 NACKs twice then ACKs.
        set_rom('{wr(16'h1111, 8'hA1), wr(16'h2222, 8'hA2), wr(16'h3333, 8'hA3), ENDE, ENDE, ENDE, ENDE, ENDE});
        run('{0, 2, 0, 0, 0, 0, 0, 0}, 0, cyc);

        // Entry 2 never ACKs; nothing fetched or written afterwards.
        set_rom('{wr(16'h1111, 8'hB1), wr(16'h2222, 8'hB2), wr(16'h3333, 8'hB3), wr(16'h4444, 8'hB4), ENDE, ENDE, ENDE, ENDE});
        run('{0, 0, 9, 0, 0, 0, 0, 0}, 0, cyc);
        repeat (50) @(negedge clk);
        chk("no_more_go", 32'(got_q.size()), 32'(exp_q.size()));
        chk("idle_after_err", 32'(busy), 0);

        // Delay of 5 units with 10-cycle ticks.
        set_rom('{dl(16'd5), ENDE, ENDE, ENDE, ENDE, ENDE, ENDE, ENDE});
        run('{0, 0, 0, 0, 0, 0, 0, 0}, 0, cyc);
        chk("delay_len", 32'(cyc >= 50), 1);

        // Engine never responds: four timed-out attempts; START while busy ignored.
        eng_stuck = 1;
        set_rom('{wr(16'h5A5A, 8'h77), ENDE, ENDE, ENDE, ENDE, ENDE, ENDE, ENDE});
        run('{9, 0, 0, 0, 0, 0, 0, 0}, 1, cyc);
        repeat (30) @(negedge clk);
        chk("busy_poke_ignored", 32'(busy), 0);
        eng_stuck = 0;

        // Reset while waiting for entry 1 to finish, then rerun from index 0.
        set_rom('{wr(16'hAAAA, 8'h11), wr(16'hBBBB, 8'h22), ENDE, ENDE, ENDE, ENDE, ENDE, ENDE});
        ack_plan.delete(); got_q.delete(); got_w.delete();
        eng_extra = 20;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        r = 0;
        while (got_w.size() < 2 && r < 2000) begin @(negedge clk); r++; end
        chk("reach_entry1", 32'(got_w.size()), 2);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_go", 32'(wr_go), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_tbl_addr", 32'(tbl_addr), 0);
        chk("mid_rst_ptr", 32'(wr_ptr), 0);
        chk("mid_rst_dat", 32'(wr_dat), 0);
        r = 0;
        while (!end_ok && r < 2000) begin @(negedge clk); r++; end
        chk("engine_idle", 32'(end_ok), 1);
        eng_extra = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run('{0, 0, 0, 0, 0, 0, 0, 0}, 0, cyc);

        // Random tables and NACK patterns.
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < NENT; i++) begin
                r = $urandom_range(0, 99);
                if (r < 70)      t[i] = wr(16'($urandom), 8'($urandom));
                else if (r < 82) t[i] = dl(16'($urandom_range(0, 3)));
                else if (r < 90) t[i] = ENDE;
                else             t[i] = {8'($urandom_range(2, 254)), 24'($urandom)};
                r = $urandom_range(0, 9);
                nk[i] = (r < 6) ? 0 : (r < 9) ? r - 5 : 9;
            end
            set_rom(t);
            run(nk, 0, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
